decode_ctrl_stage: RTL and testbench

- Registered main-control decode stage for the RV32I core, sitting between the fetch/decode pipeline register and execute.
- Decodes the 7-bit opcode into the full control bundle, including jump, JALR and illegal-opcode detection.
- Registers the bundle, PC and instruction behind a valid/ready handshake with stall and flush.
- Keeps saturating counters of decoded and illegal instructions for performance and debug.

---
 rtl/decode_ctrl_stage.sv | 189 ++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - registered RV32I main-control decode stage with handshake and statistics
module decode_ctrl_stage #(
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 16,
    parameter bit TRAP_ILLEGAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr_i,
    input  logic [PC_WIDTH-1:0]  pc_i,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr_o,
    output logic [PC_WIDTH-1:0]  pc_o,
    output logic [1:0]           ResultSrc,
    output logic                 MemWrite,
    output logic                 ALUsrc,
    output logic                 RegWrite,
    output logic                 Branch,
    output logic                 Jump,
    output logic                 JumpReg,
    output logic [2:0]           ImmSrc,
    output logic [1:0]           ALUOp,
    output logic                 illegal_o,
    output logic [CNT_WIDTH-1:0] dec_count,
    output logic [CNT_WIDTH-1:0] ill_count
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0]          NOP_INSTR = 32'h0000_0013;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef struct packed {
        logic [1:0] result_src;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic       jump_reg;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    ctrl_t                 dec;
    ctrl_t                 ctrl_d, ctrl_q;
    logic                  valid_d, valid_q;
    logic [31:0]           instr_d, instr_q;
    logic [PC_WIDTH-1:0]   pc_d, pc_q;
    logic [CNT_WIDTH-1:0]  dec_cnt_d, dec_cnt_q;
    logic [CNT_WIDTH-1:0]  ill_cnt_d, ill_cnt_q;
    logic                  load;
    logic                  consume;

    always_comb begin
        dec = '0;
        unique case (instr_i[6:0])
            OP_LOAD: begin
                dec.result_src = 2'b01;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'b001;
            end
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.imm_src = 3'b010;
                dec.alu_op  = 2'b01;
            end
            OP_IARITH: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b11;
            end
            OP_AUIPC, OP_LUI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm_src   = 3'b011;
            end
            OP_JAL: begin
                dec.result_src = 2'b10;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.imm_src    = 3'b100;
            end
            OP_JALR: begin
                dec.result_src = 2'b10;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.jump_reg   = 1'b1;
            end
            default: dec.illegal = TRAP_ILLEGAL;
        endcase
    end

    assign in_ready = ~valid_q | out_ready;
    assign load     = in_valid & in_ready & ~flush;
    // A flush in the same cycle as out_ready still counts: downstream took the bundle.
    assign consume  = valid_q & out_ready;

    always_comb begin
        ctrl_d    = ctrl_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        dec_cnt_d = dec_cnt_q;
        ill_cnt_d = ill_cnt_q;

        if (load) begin
            ctrl_d  = dec;
            instr_d = instr_i;
            pc_d    = pc_i;
        end

        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (consume) begin
            if (dec_cnt_q != CNT_MAX) begin
                dec_cnt_d = dec_cnt_q + CNT_WIDTH'(1);
            end
            if (ctrl_q.illegal && (ill_cnt_q != CNT_MAX)) begin
                ill_cnt_d = ill_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            dec_cnt_q <= '0;
            ill_cnt_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            dec_cnt_q <= dec_cnt_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign ResultSrc = ctrl_q.result_src;
    assign MemWrite  = ctrl_q.mem_write;
    assign ALUsrc    = ctrl_q.alu_src;
    assign RegWrite  = ctrl_q.reg_write;
    assign Branch    = ctrl_q.branch;
    assign Jump      = ctrl_q.jump;
    assign JumpReg   = ctrl_q.jump_reg;
    assign ImmSrc    = ctrl_q.imm_src;
    assign ALUOp     = ctrl_q.alu_op;
    assign illegal_o = ctrl_q.illegal;
    assign dec_count = dec_cnt_q;
    assign ill_count = ill_cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - self-checking bench for decode_ctrl_stage
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [31:0] instr_i, pc_i;

    always #5 clk = ~clk;

    // u0: defaults, u1: TRAP_ILLEGAL=0, u2: CNT_WIDTH=4; all share the same stimulus
    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
    logic [31:0] io0, io1, io2, po0, po1, po2;
    logic [1:0]  rs0, rs1, rs2, al0, al1, al2;
    logic        mw0, mw1, mw2, as0, as1, as2, rw0, rw1, rw2, br0, br1, br2;
    logic        j0, j1, j2, jr0, jr1, jr2, il0, il1, il2;
    logic [2:0]  im0, im1, im2;
    logic [15:0] dc0, ic0, dc1, ic1;
    logic [3:0]  dc2, ic2;

    decode_ctrl_stage u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .instr_i(instr_i),
        .pc_i(pc_i), .flush(flush), .out_valid(ov0), .out_ready(out_ready), .instr_o(io0),
        .pc_o(po0), .ResultSrc(rs0), .MemWrite(mw0), .ALUsrc(as0), .RegWrite(rw0),
        .Branch(br0), .Jump(j0), .JumpReg(jr0), .ImmSrc(im0), .ALUOp(al0),
        .illegal_o(il0), .dec_count(dc0), .ill_count(ic0));

    decode_ctrl_stage #(.TRAP_ILLEGAL(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .instr_i(instr_i),
        .pc_i(pc_i), .flush(flush), .out_valid(ov1), .out_ready(out_ready), .instr_o(io1),
        .pc_o(po1), .ResultSrc(rs1), .MemWrite(mw1), .ALUsrc(as1), .RegWrite(rw1),
        .Branch(br1), .Jump(j1), .JumpReg(jr1), .ImmSrc(im1), .ALUOp(al1),
        .illegal_o(il1), .dec_count(dc1), .ill_count(ic1));

    decode_ctrl_stage #(.CNT_WIDTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .instr_i(instr_i),
        .pc_i(pc_i), .flush(flush), .out_valid(ov2), .out_ready(out_ready), .instr_o(io2),
        .pc_o(po2), .ResultSrc(rs2), .MemWrite(mw2), .ALUsrc(as2), .RegWrite(rw2),
        .Branch(br2), .Jump(j2), .JumpReg(jr2), .ImmSrc(im2), .ALUOp(al2),
        .illegal_o(il2), .dec_count(dc2), .ill_count(ic2));

    wire [12:0] ctl0 = {rs0, mw0, as0, rw0, br0, j0, jr0, im0, al0};
    wire [12:0] ctl1 = {rs1, mw1, as1, rw1, br1, j1, jr1, im1, al1};
    wire [12:0] ctl2 = {rs2, mw2, as2, rw2, br2, j2, jr2, im2, al2};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Opcode table: {ResultSrc, MemWrite, ALUsrc, RegWrite, Branch, Jump, JumpReg, ImmSrc, ALUOp}
    localparam logic [6:0] OPS [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                                       7'b0010011, 7'b0010111, 7'b0110111, 7'b1101111, 7'b1100111};
    localparam logic [12:0] CTL [9] = '{13'b01_0_1_1_0_0_0_000_00, 13'b00_1_1_0_0_0_0_001_00,
                                        13'b00_0_0_1_0_0_0_000_10, 13'b00_0_0_0_1_0_0_010_01,
                                        13'b00_0_1_1_0_0_0_000_11, 13'b00_0_1_1_0_0_0_011_00,
                                        13'b00_0_1_1_0_0_0_011_00, 13'b10_0_1_1_0_1_0_100_00,
                                        13'b10_0_1_1_0_1_1_000_00};

    function automatic logic [12:0] exp_ctl(input logic [31:0] ins);
        for (int k = 0; k < 9; k++) if (ins[6:0] == OPS[k]) return CTL[k];
        return 13'b0;
    endfunction

    function automatic bit known_op(input logic [31:0] ins);
        for (int k = 0; k < 9; k++) if (ins[6:0] == OPS[k]) return 1'b1;
        return 1'b0;
    endfunction

    // Transaction-level model: one held bundle plus saturating tallies
    bit          m_valid;
    logic [31:0] m_instr, m_pc;
    int          m_dec, m_ill, m_dec4, m_ill4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_instr = 32'h13; m_pc = 0;
            m_dec = 0; m_ill = 0; m_dec4 = 0; m_ill4 = 0;
        end else begin
            bit take;
            if (m_valid && out_ready) begin
                m_dec  = (m_dec  < 65535) ? m_dec  + 1 : m_dec;
                m_dec4 = (m_dec4 < 15)    ? m_dec4 + 1 : m_dec4;
                if (!known_op(m_instr)) begin
                    m_ill  = (m_ill  < 65535) ? m_ill  + 1 : m_ill;
                    m_ill4 = (m_ill4 < 15)    ? m_ill4 + 1 : m_ill4;
                end
            end
            take = in_valid && (!m_valid || out_ready) && !flush;
            if (take) begin
                m_instr = instr_i;
                m_pc    = pc_i;
            end
            m_valid = flush ? 1'b0 : take ? 1'b1 : out_ready ? 1'b0 : m_valid;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", rdy0, !m_valid || out_ready);
            chk("out_valid", ov0, m_valid);
            chk("instr_o", io0, m_instr);
            chk("pc_o", po0, m_pc);
            chk("dec_count", dc0, m_dec);
            chk("ill_count", ic0, m_ill);
            chk("u1_out_valid", ov1, m_valid);
            chk("u1_dec_count", dc1, m_dec);
            chk("u1_ill_count", ic1, 0);
            chk("u2_dec_count", dc2, m_dec4);
            chk("u2_ill_count", ic2, m_ill4);
            if (m_valid) begin
                chk("ctrl", ctl0, exp_ctl(m_instr));
                chk("illegal_o", il0, !known_op(m_instr));
                chk("u1_ctrl", ctl1, exp_ctl(m_instr));
                chk("u1_illegal_o", il1, 0);
                chk("u2_ctrl", ctl2, exp_ctl(m_instr));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid = v; instr_i = ins; pc_i = pc; out_ready = ordy; flush = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        step(2);
        chk("rst_out_valid", ov0, 0);
        chk("rst_instr_o", io0, 32'h13);
        chk("rst_pc_o", po0, 0);
        chk("rst_ctrl", {ctl0, il0}, 0);
        chk("rst_counts", {dc0, ic0}, 0);
        rst_n = 1'b1;
        step();

        // lw x1,0(x2)
        drive(1, 32'h00012083, 32'h100, 1, 0);
        step();
        chk("lw_valid", ov0, 1);
        chk("lw_ResultSrc", rs0, 2'b01);
        chk("lw_ALUsrc_RegWrite", {as0, rw0}, 2'b11);
        chk("lw_ImmSrc", im0, 3'b000);
        chk("lw_pc", po0, 32'h100);
        drive(0, 0, 0, 1, 0);
        step();
        chk("lw_dec_count", dc0, 1);

        // JAL then JALR back to back
        drive(1, 32'h008000EF, 32'h104, 1, 0);
        step();
        chk("jal_jump", {j0, jr0}, 2'b10);
        chk("jal_imm", im0, 3'b100);
        chk("jal_rs", rs0, 2'b10);
        chk("jal_in_ready", rdy0, 1);
        drive(1, 32'h000080E7, 32'h108, 1, 0);
        step();
        chk("jalr_jump", {j0, jr0}, 2'b11);
        chk("jalr_imm", im0, 3'b000);
        chk("jalr_rs", rs0, 2'b10);
        drive(0, 0, 0, 1, 0);
        step();
        chk("jalr_dec_count", dc0, 3);

        // 3-cycle stall with a waiting sw
        drive(1, 32'h002081B3, 32'h10C, 1, 0);
        step();
        drive(1, 32'h0020A023, 32'h110, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in_ready", rdy0, 0);
            chk("stall_instr_o", io0, 32'h002081B3);
        end
        out_ready = 1'b1;
        step();
        chk("release_instr_o", io0, 32'h0020A023);
        chk("release_pc_o", po0, 32'h110);
        drive(0, 0, 0, 1, 0);
        step();
        chk("stall_dec_count", dc0, 5);

        // flush a held beq with an incoming addi, downstream stalled
        drive(1, 32'h00208463, 32'h114, 0, 0);
        step();
        drive(1, 32'h00100093, 32'h118, 0, 1);
        step();
        chk("flush_valid", ov0, 0);
        chk("flush_dec_count", dc0, 5);
        // flush coincident with consume still counts the consumed lui
        drive(1, 32'h123450B7, 32'h11C, 1, 0);
        step();
        drive(1, 32'h00100093, 32'h120, 1, 1);
        step();
        chk("flush_rdy_valid", ov0, 0);
        chk("flush_rdy_count", dc0, 6);

        // unknown opcode 1111111
        drive(1, 32'h0000007F, 32'h124, 1, 0);
        step();
        chk("ill_flag", il0, 1);
        chk("ill_ctrl", ctl0, 0);
        chk("ill_notrap_flag", il1, 0);
        drive(0, 0, 0, 1, 0);
        step();
        chk("ill_count", ic0, 1);
        chk("ill_notrap_count", ic1, 0);

        // 20 back-to-back auipc bundles saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h00000097, 32'h200 + 4 * i, 1, 0);
            step();
        end
        drive(0, 0, 0, 1, 0);
        step();
        chk("sat4_dec", dc2, 15);
        chk("sat16_dec", dc0, 27);

        // asynchronous reset mid-stall
        drive(1, 32'h00012083, 32'h300, 0, 0);
        step(2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", ov0, 0);
        chk("arst_counts", {dc0, ic0}, 0);
        chk("arst_u2_counts", {dc2, ic2}, 0);
        step();
        drive(0, 0, 0, 1, 0);
        rst_n = 1'b1;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
